// File: rtl/dmem_arbiter_if.sv
// Requester/RAM bundle for dmem_arbiter: two request ports, busy flag and the DataMemory side.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              rq0_req;
    logic              rq0_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic              rq0_gnt;
    logic              rq0_rvalid;
    logic [DATA_W-1:0] rq0_rdata;

    logic              rq1_req;
    logic              rq1_we;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;
    logic              rq1_gnt;
    logic              rq1_rvalid;
    logic [DATA_W-1:0] rq1_rdata;

    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output rq0_req, rq0_we, rq0_addr, rq0_wdata,
        output rq1_req, rq1_we, rq1_addr, rq1_wdata,
        input  rq0_gnt, rq0_rvalid, rq0_rdata,
        input  rq1_gnt, rq1_rvalid, rq1_rdata,
        input  busy, mem_addr, mem_wdata, mem_wren,
        output mem_q
    );

    modport slave (
        input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
        output rq0_gnt, rq0_rvalid, rq0_rdata,
        output rq1_gnt, rq1_rvalid, rq1_rdata,
        output busy, mem_addr, mem_wdata, mem_wren,
        input  mem_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port DataMemory; routes read data back to its issuer.
// Optional power-up zeroing of the RAM is enabled by defining DMEM_ARB_SCRUB_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {ST_SCRUB = 1'b0, ST_RUN = 1'b1} state_e;

`ifdef DMEM_ARB_SCRUB_EN
    localparam state_e ST_INIT = ST_SCRUB;
    logic [ADDR_W-1:0] scrub_q, scrub_d;
`else
    localparam state_e ST_INIT = ST_RUN;
`endif

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY-1:0] pipe_port_q, pipe_port_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  gnt0, gnt1, rd_issue;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Next state: scrub walks every address once, then hands over to RUN
    always_comb begin
        state_d = state_q;
`ifdef DMEM_ARB_SCRUB_EN
        scrub_d = scrub_q;
        if (state_q == ST_SCRUB) begin
            scrub_d = scrub_q + ADDR_W'(1);
            if (scrub_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
        end
`endif
    end

    // Outputs: grant selection and RAM port mux
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        bus.busy      = reset;
        bus.mem_addr  = last_addr_q;
        bus.mem_wdata = '0;
        bus.mem_wren  = 1'b0;
        if (reset) begin
            bus.mem_addr = '0;
`ifdef DMEM_ARB_SCRUB_EN
        end else if (state_q == ST_SCRUB) begin
            bus.busy     = 1'b1;
            bus.mem_addr = scrub_q;
            bus.mem_wren = 1'b1;
`endif
        end else if (state_q == ST_RUN) begin
            gnt0 = bus.rq0_req && (!bus.rq1_req || !rr_q);
            gnt1 = bus.rq1_req && !gnt0;
            if (gnt0) begin
                bus.mem_addr  = bus.rq0_addr;
                bus.mem_wdata = bus.rq0_wdata;
                bus.mem_wren  = bus.rq0_we;
            end else if (gnt1) begin
                bus.mem_addr  = bus.rq1_addr;
                bus.mem_wdata = bus.rq1_wdata;
                bus.mem_wren  = bus.rq1_we;
            end
        end
        bus.rq0_gnt = gnt0;
        bus.rq1_gnt = gnt1;
    end

    // Pointer, held address and read-return tracking
    always_comb begin
        rd_issue    = (gnt0 && !bus.rq0_we) || (gnt1 && !bus.rq1_we);
        rr_d        = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : rr_q);
        last_addr_d = bus.mem_addr;
        pipe_vld_d  = pipe_vld_q << 1;
        pipe_port_d = pipe_port_q << 1;
        pipe_vld_d[0]  = rd_issue;
        pipe_port_d[0] = gnt1;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            if (pipe_port_q[RD_LATENCY-1]) begin
                rvalid1_d = 1'b1;
                rdata1_d  = bus.mem_q;
            end else begin
                rvalid0_d = 1'b1;
                rdata0_d  = bus.mem_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= 1'b0;
            last_addr_q <= '0;
            pipe_vld_q  <= '0;
            pipe_port_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef DMEM_ARB_SCRUB_EN
            scrub_q     <= '0;
`endif
        end else begin
            rr_q        <= rr_d;
            last_addr_q <= last_addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_port_q <= pipe_port_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_SCRUB_EN
            scrub_q     <= scrub_d;
`endif
        end
    end

    assign bus.rq0_rvalid = rvalid0_q;
    assign bus.rq0_rdata  = rdata0_q;
    assign bus.rq1_rvalid = rvalid1_q;
    assign bus.rq1_rdata  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, per-cycle reference model of grants/returns, directed scenarios.
module tb_dmem_arbiter;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 1;
`ifdef DMEM_ARB_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int checks   = 0;
    int failures = 0;

    function automatic logic [DW-1:0] init_word(int i);
        return DW'(32'(i) * 32'd4099 + 32'd165);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
    end

    // DataMemory stand-in: one-cycle registered read
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= ram[bus.mem_addr];
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    bit            m_rr;
    logic [AW-1:0] m_last;
    bit            m_rv[2];
    logic [DW-1:0] m_rd[2];
    bit            m_ok = 1'b0;
    int            cyc = 0;
    int            scrub_idx = -1;

    always @(negedge clk) begin
        bit            g0, g1, p, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        g0 = bus.rq0_req && (!bus.rq1_req || !m_rr);
        g1 = bus.rq1_req && !g0;
        p  = g1;
        we = p ? bus.rq1_we : bus.rq0_we;
        a  = p ? bus.rq1_addr : bus.rq0_addr;
        d  = p ? bus.rq1_wdata : bus.rq0_wdata;
        if (m_ok) begin
            chk("rq0_rvalid", 32'(bus.rq0_rvalid), 32'(m_rv[0]));
            chk("rq1_rvalid", 32'(bus.rq1_rvalid), 32'(m_rv[1]));
            chk("rq0_rdata", 32'(bus.rq0_rdata), 32'(m_rd[0]));
            chk("rq1_rdata", 32'(bus.rq1_rdata), 32'(m_rd[1]));
            if (reset) begin
                chk("rst_busy", 32'(bus.busy), 32'd1);
                chk("rst_gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd0);
                chk("rst_wren", 32'(bus.mem_wren), 32'd0);
                chk("rst_addr", 32'(bus.mem_addr), 32'd0);
            end else if (scrub_idx >= 0) begin
                chk("scr_busy", 32'(bus.busy), 32'd1);
                chk("scr_gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd0);
                chk("scr_wren", 32'(bus.mem_wren), 32'd1);
                chk("scr_addr", 32'(bus.mem_addr), 32'(scrub_idx));
                chk("scr_wdata", 32'(bus.mem_wdata), 32'd0);
            end else begin
                chk("busy", 32'(bus.busy), 32'd0);
                chk("gnt", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, {30'd0, g1, g0});
                chk("mem_wren", 32'(bus.mem_wren), 32'((g0 || g1) && we));
                chk("mem_addr", 32'(bus.mem_addr), 32'((g0 || g1) ? a : m_last));
                if (g0 || g1) chk("mem_wdata", 32'(bus.mem_wdata), 32'(d));
            end
        end
        if (reset) begin
            m_rr = 1'b0;
            m_last = '0;
            pend.delete();
            m_rv = '{1'b0, 1'b0};
            m_rd = '{'0, '0};
            scrub_idx = SCRUB ? 0 : -1;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (scrub_idx >= 0) begin
                ref_mem[scrub_idx] = '0;
                m_last = AW'(scrub_idx);
                scrub_idx = (scrub_idx == DEPTH - 1) ? -1 : scrub_idx + 1;
            end else if (g0 || g1) begin
                m_last = a;
                m_rr = ~p;
                if (we) ref_mem[a] = d;
                else pend.push_back('{due: cyc + 1 + LAT, port: p, data: ref_mem[a]});
            end
            m_rv = '{1'b0, 1'b0};
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                m_rv[pend[0].port] = 1'b1;
                m_rd[pend[0].port] = pend[0].data;
                void'(pend.pop_front());
            end
        end
        cyc++;
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int p, bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (p == 0) begin
            bus.rq0_req = req; bus.rq0_we = we; bus.rq0_addr = a; bus.rq0_wdata = d;
        end else begin
            bus.rq1_req = req; bus.rq1_we = we; bus.rq1_addr = a; bus.rq1_wdata = d;
        end
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic release_reset();
        int n;
        reset = 1'b0;
        #1;
        n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        chk("busy_cycles_after_release", 32'(n), SCRUB ? 32'd256 : 32'd0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (3) tick();
        chk("lit_reset_rvalid0", 32'(bus.rq0_rvalid), 32'd0);
        chk("lit_reset_rdata0", 32'(bus.rq0_rdata), 32'd0);
        chk("lit_reset_busy", 32'(bus.busy), 32'd1);
        chk("lit_reset_addr", 32'(bus.mem_addr), 32'd0);

        // Scrub: held request is not granted until scrub completes
        if (SCRUB) drv(0, 1'b1, 1'b0, 8'h80, '0);
        release_reset();
        if (SCRUB) begin
            chk("lit_scrub_first_gnt", 32'(bus.rq0_gnt), 32'd1);
            tick();
            idle();
            tick();
            chk("lit_scrub_rvalid", 32'(bus.rq0_rvalid), 32'd1);
            chk("lit_scrub_rdata", 32'(bus.rq0_rdata), 32'h0000);
            tick();
        end

        // Write then read-back on port 0
        drv(0, 1'b1, 1'b1, 8'h10, 16'hABCD);
        #1 chk("lit_t1_wr_gnt", 32'(bus.rq0_gnt), 32'd1);
        tick();
        drv(0, 1'b1, 1'b0, 8'h10, '0);
        #1 chk("lit_t1_rd_gnt", 32'(bus.rq0_gnt), 32'd1);
        tick();
        idle();
        chk("lit_t1_no_early_rvalid", 32'(bus.rq0_rvalid), 32'd0);
        tick();
        chk("lit_t1_rvalid", 32'(bus.rq0_rvalid), 32'd1);
        chk("lit_t1_rdata", 32'(bus.rq0_rdata), 32'hABCD);
        tick();

        // Both ports reading every cycle from reset
        reset = 1'b1;
        repeat (2) tick();
        drv(0, 1'b1, 1'b0, 8'h20, '0);
        drv(1, 1'b1, 1'b0, 8'h21, '0);
        release_reset();
        chk("lit_t2_gnt_c0", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd1);
        tick();
        chk("lit_t2_gnt_c1", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd2);
        tick();
        chk("lit_t2_gnt_c2", {30'd0, bus.rq1_gnt, bus.rq0_gnt}, 32'd1);
        chk("lit_t2_rv_c2", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, 32'd1);
        tick();
        chk("lit_t2_rv_c3", {30'd0, bus.rq1_rvalid, bus.rq0_rvalid}, 32'd2);
        tick();
        idle();
        repeat (3) tick();

        // Port 1 back-to-back reads of pre-written words
        for (int i = 0; i < 4; i++) begin
            drv(1, 1'b1, 1'b1, AW'(i), DW'(i + 1));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drv(1, 1'b1, 1'b0, AW'(i), '0);
            else idle();
            if (i >= 2) begin
                chk("lit_t3_rvalid", 32'(bus.rq1_rvalid), 32'd1);
                chk("lit_t3_rdata", 32'(bus.rq1_rdata), 32'(i - 1));
                chk("lit_t3_rq0_quiet", 32'(bus.rq0_rvalid), 32'd0);
            end
            tick();
        end
        repeat (2) tick();

        // Reset right after a read grant cancels its return
        drv(0, 1'b1, 1'b0, 8'h10, '0);
        tick();
        idle();
        reset = 1'b1;
        #1 chk("lit_t4_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("lit_t4_rvalid", 32'(bus.rq0_rvalid), 32'd0);
        chk("lit_t4_rdata", 32'(bus.rq0_rdata), 32'd0);
        chk("lit_t4_wren", 32'(bus.mem_wren), 32'd0);
        tick();
        release_reset();
        chk("lit_t4_post_rvalid", 32'(bus.rq0_rvalid), 32'd0);
        tick();

        // Top address write/read, then address 0
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drv(0, 1'b1, 1'b1, 8'hFF, 16'h5555);
                1: drv(0, 1'b1, 1'b0, 8'hFF, '0);
                2: drv(0, 1'b1, 1'b0, 8'h00, '0);
                default: idle();
            endcase
            if (i == 3) chk("lit_t5_ff", {15'd0, bus.rq0_rvalid, bus.rq0_rdata}, 32'h1_5555);
            if (i == 4) chk("lit_t5_00", {15'd0, bus.rq0_rvalid, bus.rq0_rdata}, SCRUB ? 32'h1_0000 : 32'h1_0001);
            tick();
        end
        idle();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
